costas_lock_detect: RTL

//  Sits directly downstream of the polar Costas carrier-recovery loop and consumes its I/Q LPF outputs.

---
 rtl/costas_lock_detect.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/costas_lock_detect.sv
// Carrier-lock detector for the Costas loop: windowed average of |I|-|Q|,
// hysteresis lock FSM, and hard BPSK decisions from the sign of I while locked.
module costas_lock_detect #(
    parameter int DW        = 26,
    parameter int WIN_LOG2  = 10,
    parameter int TH_LOCK   = 2**23,
    parameter int TH_UNLOCK = 2**22,
    parameter int N_CONFIRM = 4,
    parameter int N_LOSE    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] di,
    input  logic signed [DW-1:0] dq,
    output logic signed [DW:0]   metric,
    output logic                 metric_valid,
    output logic [1:0]           lock_state,
    output logic                 lock,
    output logic                 bit_out,
    output logic                 bit_valid
);

    localparam int AW = DW + 1 + WIN_LOG2;
    localparam logic signed [DW:0]  TH_LOCK_S   = (DW+1)'(TH_LOCK);
    localparam logic signed [DW:0]  TH_UNLOCK_S = (DW+1)'(TH_UNLOCK);
    localparam logic [3:0]          N_CONFIRM_C = 4'(N_CONFIRM);
    localparam logic [3:0]          N_LOSE_C    = 4'(N_LOSE);
    localparam logic [3:0]          CNT_ONE     = 4'd1;
    localparam logic [WIN_LOG2-1:0] WIN_ONE     = WIN_LOG2'(1);
    localparam logic [DW-2:0]       MAG_MAX     = '1;

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCK   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t state_reg, state_next;
    logic [3:0] ccnt_reg, ccnt_next, ccnt_inc;

    // Stage 1: saturated magnitudes of both channels
    logic signed [DW-1:0] din_ch [2];
    logic [DW-2:0]        mag    [2];
    logic signed [DW:0]   e_next;

    assign din_ch[0] = di;
    assign din_ch[1] = dq;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mag
            // The most negative input has no positive twin, so it clamps to full scale.
            assign mag[gi] = !din_ch[gi][DW-1]           ? din_ch[gi][DW-2:0] :
                             (din_ch[gi][DW-2:0] == '0)  ? MAG_MAX :
                                                           -din_ch[gi][DW-2:0];
        end
    endgenerate

    assign e_next = $signed({2'b00, mag[0]}) - $signed({2'b00, mag[1]});

    logic signed [DW:0] e_reg;
    logic               e_v_reg;
    logic               bit_out_reg;
    logic               bit_valid_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_reg         <= '0;
            e_v_reg       <= 1'b0;
            bit_out_reg   <= 1'b0;
            bit_valid_reg <= 1'b0;
        end else begin
            e_v_reg       <= din_valid;
            bit_valid_reg <= din_valid & state_reg[1];
            if (din_valid) begin
                e_reg       <= e_next;
                bit_out_reg <= ~di[DW-1];
            end
        end
    end

    // Stage 2: window accumulator; the top slice of the sum is the floored average
    logic signed [AW-1:0]  acc_reg, acc_sum;
    logic [WIN_LOG2-1:0]   wcnt_reg;
    logic signed [DW:0]    metric_reg;
    logic                  metric_valid_reg;

    assign acc_sum = acc_reg + {{(AW-DW-1){e_reg[DW]}}, e_reg};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg          <= '0;
            wcnt_reg         <= '0;
            metric_reg       <= '0;
            metric_valid_reg <= 1'b0;
        end else begin
            metric_valid_reg <= 1'b0;
            if (e_v_reg) begin
                if (&wcnt_reg) begin
                    metric_reg       <= acc_sum[AW-1:WIN_LOG2];
                    metric_valid_reg <= 1'b1;
                    acc_reg          <= '0;
                    wcnt_reg         <= '0;
                end else begin
                    acc_reg  <= acc_sum;
                    wcnt_reg <= wcnt_reg + WIN_ONE;
                end
            end
        end
    end

    // Stage 3: hysteresis lock FSM, evaluated once per finished window
    logic win_good, win_bad;
    assign win_good = (metric_reg >= TH_LOCK_S);
    assign win_bad  = (metric_reg <  TH_UNLOCK_S);
    assign ccnt_inc = ccnt_reg + CNT_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_UNLOCK;
            ccnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ccnt_reg  <= ccnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ccnt_next  = ccnt_reg;
        if (metric_valid_reg) begin
            case (state_reg)
                ST_UNLOCK: if (win_good) begin
                    if (N_CONFIRM == 1) begin
                        state_next = ST_LOCK;
                        ccnt_next  = '0;
                    end else begin
                        state_next = ST_CHECK;
                        ccnt_next  = CNT_ONE;
                    end
                end
                ST_CHECK: if (win_good) begin
                    if (ccnt_inc == N_CONFIRM_C) begin
                        state_next = ST_LOCK;
                        ccnt_next  = '0;
                    end else begin
                        ccnt_next  = ccnt_inc;
                    end
                end else begin
                    state_next = ST_UNLOCK;
                    ccnt_next  = '0;
                end
                ST_LOCK: if (win_bad) begin
                    if (N_LOSE == 1) begin
                        state_next = ST_UNLOCK;
                        ccnt_next  = '0;
                    end else begin
                        state_next = ST_HOLD;
                        ccnt_next  = CNT_ONE;
                    end
                end
                ST_HOLD: if (win_bad) begin
                    if (ccnt_inc == N_LOSE_C) begin
                        state_next = ST_UNLOCK;
                        ccnt_next  = '0;
                    end else begin
                        ccnt_next  = ccnt_inc;
                    end
                end else begin
                    state_next = ST_LOCK;
                    ccnt_next  = '0;
                end
                default: begin
                    state_next = ST_UNLOCK;
                    ccnt_next  = '0;
                end
            endcase
        end
    end

    assign metric       = metric_reg;
    assign metric_valid = metric_valid_reg;
    assign lock_state   = state_reg;
    assign lock         = state_reg[1];
    assign bit_out      = bit_out_reg;
    assign bit_valid    = bit_valid_reg;

endmodule
